// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine.
// The output-count helper lets the top level know when the frame is complete.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_MAC  = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int TAPS  = 9;
    localparam int KSIZE = 3;
    localparam int TAP_W = 4;

    function automatic int out_count(input int img_w, input int img_h);
        return (img_h - 2) * (img_w - 2);
    endfunction

endpackage

// File: rtl/conv_window.sv
// Two line buffers plus a 3x3 sliding window over a raster pixel stream.
// Window tap r*3+c is exposed on win_flat; win_done flags a window-completing pixel.
module conv_window
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     accept,
    input  logic [DATA_W-1:0]        pix,
    output logic                     win_done,
    output logic [TAPS*DATA_W-1:0]   win_flat
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = $clog2(IMG_H + 1);

    logic [COL_W-1:0]  col_reg, col_next;
    logic [ROW_W-1:0]  row_reg, row_next;
    logic [DATA_W-1:0] lb0_mem [IMG_W];
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] rd0_reg, rd1_reg;
    logic [DATA_W-1:0] col_in [KSIZE];

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (clear) begin
            col_next = '0;
            row_next = '0;
        end else if (accept) begin
            if (col_reg == COL_W'(IMG_W - 1)) begin
                col_next = '0;
                row_next = row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // Reads are addressed one cycle ahead so rd*_reg always holds column col_reg.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[col_reg] <= rd1_reg;
            lb1_mem[col_reg] <= pix;
        end
        rd0_reg <= lb0_mem[col_next];
        rd1_reg <= lb1_mem[col_next];
    end

    assign col_in[0] = rd0_reg;
    assign col_in[1] = rd1_reg;
    assign col_in[2] = pix;

    genvar gi, gj;
    generate
        for (gi = 0; gi < KSIZE; gi++) begin : g_row
            logic [DATA_W-1:0] cell_reg [KSIZE];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int c = 0; c < KSIZE; c++) cell_reg[c] <= '0;
                end else if (accept) begin
                    for (int c = 0; c < KSIZE - 1; c++) cell_reg[c] <= cell_reg[c+1];
                    cell_reg[KSIZE-1] <= col_in[gi];
                end
            end

            for (gj = 0; gj < KSIZE; gj++) begin : g_col
                assign win_flat[(gi*KSIZE+gj)*DATA_W +: DATA_W] = cell_reg[gj];
            end
        end
    endgenerate

    assign win_done = accept && (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));

endmodule

// File: rtl/conv2d_stream_engine.sv
// 3x3 streaming convolution: FSM, kernel registers, sequential MAC and ReLU.
// One tap is multiplied per cycle; results leave on a valid/ready stream.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              relu_en,
    input  logic              kw_we,
    input  logic [3:0]        kw_addr,
    input  logic [DATA_W-1:0] kw_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data
);

    localparam int NOUT  = out_count(IMG_W, IMG_H);
    localparam int CNT_W = $clog2(NOUT + 1);

    state_t                   state_reg, state_next;
    logic [TAP_W-1:0]         tap_reg;
    logic [CNT_W-1:0]         out_cnt_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     relu_reg;
    logic [TAPS*DATA_W-1:0]   kw_flat;
    logic [TAPS*DATA_W-1:0]   win_flat;
    logic                     start_go, accept, out_hs, win_done;
    logic signed [DATA_W-1:0]   tap_w, tap_p;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign start_go = (state_reg == ST_IDLE) && start;
    assign accept   = (state_reg == ST_FILL) && pix_valid;
    assign out_hs   = (state_reg == ST_OUT) && out_ready;

    conv_window #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .DATA_W (DATA_W)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_go),
        .accept   (accept),
        .pix      (pix_data),
        .win_done (win_done),
        .win_flat (win_flat)
    );

    // Kernel writes land only while idle; addresses beyond the last tap are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_kw
            logic [DATA_W-1:0] w_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    w_reg <= '0;
                else if ((state_reg == ST_IDLE) && kw_we && (kw_addr == 4'(gi)))
                    w_reg <= kw_data;
            end
            assign kw_flat[gi*DATA_W +: DATA_W] = w_reg;
        end
    endgenerate

    assign tap_w    = $signed(kw_flat[tap_reg*DATA_W +: DATA_W]);
    assign tap_p    = $signed(win_flat[tap_reg*DATA_W +: DATA_W]);
    assign prod     = tap_w * tap_p;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_FILL;
            ST_FILL: if (win_done) state_next = ST_MAC;
            ST_MAC:  if (tap_reg == TAP_W'(TAPS - 1)) state_next = ST_OUT;
            ST_OUT: begin
                if (out_ready)
                    state_next = (out_cnt_reg == CNT_W'(NOUT - 1)) ? ST_DONE : ST_FILL;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != ST_IDLE);
        done      = (state_reg == ST_DONE);
        pix_ready = (state_reg == ST_FILL);
        out_valid = (state_reg == ST_OUT);
        out_data  = '0;
        if (state_reg == ST_OUT)
            out_data = (relu_reg && acc_reg[ACC_W-1]) ? '0 : acc_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_reg     <= '0;
            acc_reg     <= '0;
            out_cnt_reg <= '0;
            relu_reg    <= 1'b0;
        end else begin
            if (start_go) begin
                relu_reg    <= relu_en;
                out_cnt_reg <= '0;
            end
            if (state_reg == ST_MAC) begin
                tap_reg <= (tap_reg == TAP_W'(TAPS - 1)) ? '0 : tap_reg + 1'b1;
                acc_reg <= (tap_reg == '0) ? prod_ext : acc_reg + prod_ext;
            end
            if (out_hs)
                out_cnt_reg <= out_cnt_reg + 1'b1;
        end
    end

endmodule
